// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade driver and its per-LED PWM channels.
package led_pkg;

    localparam int NUM_LEDS  = 8;
    localparam int PWM_W_DEF = 8;

    typedef enum logic {
        IDLE,
        FADING
    } fade_state_t;

    typedef logic [PWM_W_DEF-1:0] bright_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED lane: a brightness register that ramps by a saturating STEP toward
// its endpoint, and a registered compare against the shared PWM counter.
module led_pwm_channel #(
    parameter int PWM_W = 8,
    parameter int STEP  = 17
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             dir,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led_o,
    output logic             at_end
);

    localparam logic [PWM_W-1:0] MAX    = '1;
    localparam logic [PWM_W:0]   STEP_W = (PWM_W+1)'(STEP);

    logic [PWM_W-1:0] bright_q, bright_d;
    logic             led_q, led_d;
    logic [PWM_W:0]   sum;

    assign at_end = dir ? (bright_q == MAX) : (bright_q == '0);
    assign led_o  = led_q;

    // The sum is one bit wider so the clamp at MAX can see the overflow.
    always_comb begin
        sum      = {1'b0, bright_q} + STEP_W;
        bright_d = bright_q;
        if (step_en) begin
            if (dir) begin
                bright_d = (sum > {1'b0, MAX}) ? MAX : sum[PWM_W-1:0];
            end else begin
                bright_d = ({1'b0, bright_q} < STEP_W) ? '0 : (bright_q - STEP_W[PWM_W-1:0]);
            end
        end
        led_d = (bright_q == MAX) || (bright_q > pwm_cnt);
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            bright_q <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// Accepts an 8-bit on/off pattern and ramps each LED's PWM brightness toward
// full-on or off, one STEP every STEP_DIV clocks, driving the pins with PWM.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int STEP     = 17,
    parameter int STEP_DIV = 400000
) (
    input  logic                hwclk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                pattern_valid,
    output logic                pattern_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy
);

    localparam int                CNT_W       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  STEP_RELOAD = CNT_W'(STEP_DIV - 1);

    fade_state_t         state_q, state_d;
    logic [NUM_LEDS-1:0] target_q, target_d;
    logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
    logic [PWM_W-1:0]    pwm_cnt_q;
    logic [NUM_LEDS-1:0] at_end;
    logic                step_en;

    // Completion is judged on registered brightness, so a no-op pattern still
    // costs exactly one FADING cycle.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        step_cnt_d    = step_cnt_q;
        step_en       = 1'b0;
        pattern_ready = (state_q == IDLE) && !rst;
        busy          = (state_q == FADING);
        case (state_q)
            IDLE: begin
                if (pattern_valid && pattern_ready) begin
                    target_d   = pattern;
                    step_cnt_d = STEP_RELOAD;
                    state_d    = FADING;
                end
            end
            FADING: begin
                if (&at_end) begin
                    state_d = IDLE;
                end
                if (step_cnt_q == '0) begin
                    step_en    = 1'b1;
                    step_cnt_d = STEP_RELOAD;
                end else begin
                    step_cnt_d = step_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_q + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_pwm_channel #(
            .PWM_W(PWM_W),
            .STEP (STEP)
        ) u_chan (
            .hwclk  (hwclk),
            .rst    (rst),
            .step_en(step_en),
            .dir    (target_q[i]),
            .pwm_cnt(pwm_cnt_q),
            .led_o  (led[i]),
            .at_end (at_end[i])
        );
    end

endmodule
